// File: rtl/io_port_bank_pkg.sv
// rtl/io_port_bank_pkg.sv - shared decode constants and channel config type for io_port_bank
package io_port_bank_pkg;

    localparam int BUS_W = 8;

    // Partial decodes as used by the 128K/+2A paging and ULA border latches
    localparam logic [15:0] IO_7FFD_ADDR = 16'h7FFD;
    localparam logic [15:0] IO_7FFD_MASK = 16'h8002;
    localparam logic [15:0] IO_DFFD_ADDR = 16'hDFFD;
    localparam logic [15:0] IO_DFFD_MASK = 16'hF002;
    localparam logic [15:0] IO_1FFD_ADDR = 16'h1FFD;
    localparam logic [15:0] IO_1FFD_MASK = 16'hF002;
    localparam logic [15:0] IO_FE_ADDR   = 16'h00FE;
    localparam logic [15:0] IO_FE_MASK   = 16'h0001;

    typedef struct packed {
        logic [15:0] addr_match;
        logic [15:0] addr_mask;
        logic [7:0]  reset_val;
        logic        readable;
        logic        lockable;
        logic        sync_wr;
    } io_port_cfg_t;

    function automatic logic addr_hit(input logic [15:0] a, input logic [15:0] match,
                                      input logic [15:0] mask);
        return ((a ^ match) & mask) == 16'h0000;
    endfunction

endpackage

// File: rtl/io_port_bank_if.sv
// rtl/io_port_bank_if.sv - CPU I/O bus view shared by the decoder side and the port bank
interface io_port_bank_if;
    logic [15:0] bus_a;
    logic [7:0]  bus_d;
    logic        bus_ioreq;
    logic        bus_rd;
    logic        bus_wr;
    logic [7:0]  d_out;
    logic        d_out_active;

    modport master (
        output bus_a, bus_d, bus_ioreq, bus_rd, bus_wr,
        input  d_out, d_out_active
    );

    modport slave (
        input  bus_a, bus_d, bus_ioreq, bus_rd, bus_wr,
        output d_out, d_out_active
    );
endinterface

// File: rtl/io_port_bank_chan.sv
// rtl/io_port_bank_chan.sv - one latch register with optional sticky lock and sync-gated commit
module io_port_chan #(
    parameter int         W         = 8,
    parameter logic [W-1:0] RESET_VAL = '0,
    parameter bit         LOCKABLE  = 1'b0,
    parameter int         LOCK_POS  = 5,
    parameter bit         SYNC_WR   = 1'b0
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         sel_i,
    input  logic         sync_ck_i,
    input  logic         unlock_i,
    input  logic [7:0]   wr_data_i,
    output logic [W-1:0] q_o,
    output logic         locked_o,
    output logic         wr_stb_o,
    output logic         done_o
);

    logic [W-1:0] q_q, q_d;
    logic         locked_q, locked_d;
    logic         stb_q;
    logic         go, blocked, commit;

    // A blocked write consumes the I/O cycle at once; it never waits for sync_ck
    always_comb begin
        blocked = sel_i & locked_q & ~unlock_i;
        go      = sel_i & (~SYNC_WR | sync_ck_i);
        commit  = go & ~blocked;
        done_o  = commit | blocked;
        q_d     = commit ? wr_data_i[W-1:0] : q_q;
    end

    if (LOCKABLE && (LOCK_POS < W)) begin : g_lock
        assign locked_d = commit ? wr_data_i[LOCK_POS] : locked_q;
    end else begin : g_nolock
        assign locked_d = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q      <= RESET_VAL;
            locked_q <= 1'b0;
            stb_q    <= 1'b0;
        end else begin
            q_q      <= q_d;
            locked_q <= locked_d;
            stb_q    <= commit;
        end
    end

    assign q_o      = q_q;
    assign locked_o = locked_q;
    assign wr_stb_o = stb_q;

endmodule

// File: rtl/io_port_bank.sv
// rtl/io_port_bank.sv - bank of CPU-writable I/O latches with priority decode and read-back
module io_port_bank
    import io_port_bank_pkg::*;
#(
    parameter int                  NPORTS     = 4,
    parameter int                  W          = 8,
    parameter logic [NPORTS*16-1:0] ADDR_MATCH = {NPORTS{16'h0000}},
    parameter logic [NPORTS*16-1:0] ADDR_MASK  = {NPORTS{16'hFFFF}},
    parameter logic [NPORTS*W-1:0]  RESET_VAL  = {NPORTS*W{1'b0}},
    parameter logic [NPORTS-1:0]    READABLE   = {NPORTS{1'b0}},
    parameter logic [NPORTS-1:0]    LOCKABLE   = {NPORTS{1'b0}},
    parameter int                  LOCK_POS   = 5,
    parameter logic [NPORTS-1:0]    SYNC_WR    = {NPORTS{1'b0}}
) (
    input  logic                clk28,
    input  logic                rst_n,
    input  logic [NPORTS-1:0]   en,
    io_port_bank_if.slave       bus,
    input  logic                sync_ck,
    input  logic                unlock,
    output logic [NPORTS*W-1:0] regs,
    output logic [NPORTS-1:0]   wr_stb,
    output logic [NPORTS-1:0]   locked
);

    logic [W-1:0]      chan_q [NPORTS];
    logic [NPORTS-1:0] sel_oh, done_vec;
    logic              any_hit, rd_ok, wr_req, rd_act;
    logic [W-1:0]      rd_data;
    logic              wr_done_q, wr_done_d;
    logic [7:0]        d_out_q, d_out_d;
    logic              d_act_q, d_act_d;

    // Walking up from channel 0 makes the lowest-index hit win
    always_comb begin
        sel_oh  = '0;
        any_hit = 1'b0;
        rd_ok   = 1'b0;
        rd_data = '0;
        for (int i = 0; i < NPORTS; i++) begin
            if (!any_hit && en[i] && bus.bus_ioreq &&
                addr_hit(bus.bus_a, ADDR_MATCH[16*i +: 16], ADDR_MASK[16*i +: 16])) begin
                any_hit   = 1'b1;
                sel_oh[i] = 1'b1;
                rd_data   = chan_q[i];
                rd_ok     = READABLE[i];
            end
        end
    end

    always_comb begin
        wr_req    = bus.bus_ioreq & bus.bus_wr & any_hit & ~wr_done_q;
        rd_act    = bus.bus_ioreq & bus.bus_rd & ~bus.bus_wr & any_hit & rd_ok;
        wr_done_d = (bus.bus_ioreq & bus.bus_wr) ? (wr_done_q | (|done_vec)) : 1'b0;
        d_act_d   = rd_act;
        d_out_d   = rd_act ? 8'(rd_data) : 8'h00;
    end

    for (genvar g = 0; g < NPORTS; g++) begin : g_chan
        io_port_chan #(
            .W        (W),
            .RESET_VAL(RESET_VAL[W*g +: W]),
            .LOCKABLE (LOCKABLE[g]),
            .LOCK_POS (LOCK_POS),
            .SYNC_WR  (SYNC_WR[g])
        ) u_chan (
            .clk_i    (clk28),
            .rst_ni   (rst_n),
            .sel_i    (wr_req & sel_oh[g]),
            .sync_ck_i(sync_ck),
            .unlock_i (unlock),
            .wr_data_i(bus.bus_d),
            .q_o      (chan_q[g]),
            .locked_o (locked[g]),
            .wr_stb_o (wr_stb[g]),
            .done_o   (done_vec[g])
        );
        assign regs[W*g +: W] = chan_q[g];
    end

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            wr_done_q <= 1'b0;
            d_out_q   <= 8'h00;
            d_act_q   <= 1'b0;
        end else begin
            wr_done_q <= wr_done_d;
            d_out_q   <= d_out_d;
            d_act_q   <= d_act_d;
        end
    end

    assign bus.d_out        = d_out_q;
    assign bus.d_out_active = d_act_q;

endmodule

// File: tb/tb_io_port_bank.sv
// tb/tb_io_port_bank.sv - randomized and directed self-checking bench for io_port_bank
module tb_io_port_bank;
    import io_port_bank_pkg::*;

    localparam io_port_cfg_t CFG0 = '{addr_match: IO_7FFD_ADDR, addr_mask: IO_7FFD_MASK,
        reset_val: 8'h00, readable: 1'b1, lockable: 1'b1, sync_wr: 1'b0};
    localparam io_port_cfg_t CFG1 = '{addr_match: IO_FE_ADDR, addr_mask: IO_FE_MASK,
        reset_val: 8'h10, readable: 1'b1, lockable: 1'b0, sync_wr: 1'b0};
    localparam io_port_cfg_t CFG2 = '{addr_match: IO_DFFD_ADDR, addr_mask: IO_DFFD_MASK,
        reset_val: 8'h33, readable: 1'b1, lockable: 1'b0, sync_wr: 1'b1};
    localparam io_port_cfg_t CFG3 = '{addr_match: IO_1FFD_ADDR, addr_mask: IO_1FFD_MASK,
        reset_val: 8'h44, readable: 1'b0, lockable: 1'b0, sync_wr: 1'b0};

    localparam logic [63:0] P_MATCH = {CFG3.addr_match, CFG2.addr_match, CFG1.addr_match, CFG0.addr_match};
    localparam logic [63:0] P_MASK  = {CFG3.addr_mask, CFG2.addr_mask, CFG1.addr_mask, CFG0.addr_mask};
    localparam logic [31:0] P_RST   = {CFG3.reset_val, CFG2.reset_val, CFG1.reset_val, CFG0.reset_val};
    localparam logic [3:0]  P_RD    = {CFG3.readable, CFG2.readable, CFG1.readable, CFG0.readable};
    localparam logic [3:0]  P_LK    = {CFG3.lockable, CFG2.lockable, CFG1.lockable, CFG0.lockable};
    localparam logic [3:0]  P_SY    = {CFG3.sync_wr, CFG2.sync_wr, CFG1.sync_wr, CFG0.sync_wr};

    logic        clk28 = 1'b0;
    logic        rst_n;
    logic [3:0]  en;
    logic        sync_ck, unlock;
    logic [31:0] regs;
    logic [3:0]  wr_stb, locked;

    io_port_bank_if bus_if ();

    io_port_bank #(
        .NPORTS(4), .W(8), .ADDR_MATCH(P_MATCH), .ADDR_MASK(P_MASK), .RESET_VAL(P_RST),
        .READABLE(P_RD), .LOCKABLE(P_LK), .LOCK_POS(5), .SYNC_WR(P_SY)
    ) dut (
        .clk28  (clk28),
        .rst_n  (rst_n),
        .en     (en),
        .bus    (bus_if),
        .sync_ck(sync_ck),
        .unlock (unlock),
        .regs   (regs),
        .wr_stb (wr_stb),
        .locked (locked)
    );

    always #5 clk28 = ~clk28;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: registers as bytes, a per-I/O-cycle "already written" flag, outputs for next compare
    logic [7:0] m_reg [4];
    logic [3:0] m_lock, m_stb;
    logic [7:0] m_dout;
    logic       m_act, m_done, m_valid = 1'b0;

    always @(posedge clk28) begin
        int s;
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) m_reg[i] = P_RST[8*i +: 8];
            m_lock = '0; m_stb = '0; m_dout = '0; m_act = 1'b0; m_done = 1'b0;
        end else begin
            s = -1;
            for (int i = 0; i < 4; i++)
                if (s < 0 && en[i] && bus_if.bus_ioreq &&
                    ((bus_if.bus_a ^ P_MATCH[16*i +: 16]) & P_MASK[16*i +: 16]) == 16'h0)
                    s = i;
            m_stb  = '0;
            m_act  = bus_if.bus_ioreq && bus_if.bus_rd && !bus_if.bus_wr && s >= 0 && P_RD[s];
            m_dout = m_act ? m_reg[s] : 8'h00;
            if (!(bus_if.bus_ioreq && bus_if.bus_wr)) begin
                m_done = 1'b0;
            end else if (!m_done && s >= 0) begin
                if (m_lock[s] && !unlock) begin
                    m_done = 1'b1;
                end else if (!P_SY[s] || sync_ck) begin
                    m_reg[s] = bus_if.bus_d;
                    m_stb[s] = 1'b1;
                    if (P_LK[s]) m_lock[s] = bus_if.bus_d[5];
                    m_done = 1'b1;
                end
            end
        end
        m_valid = 1'b1;
    end

    always @(negedge clk28) begin
        if (m_valid) begin
            chk("regs", regs, {m_reg[3], m_reg[2], m_reg[1], m_reg[0]});
            chk("wr_stb", {28'h0, wr_stb}, {28'h0, m_stb});
            chk("locked", {28'h0, locked}, {28'h0, m_lock});
            chk("d_out", {24'h0, bus_if.d_out}, {24'h0, m_dout});
            chk("d_out_active", {31'h0, bus_if.d_out_active}, {31'h0, m_act});
        end
    end

    task automatic idle();
        bus_if.bus_ioreq = 1'b0; bus_if.bus_rd = 1'b0; bus_if.bus_wr = 1'b0; sync_ck = 1'b0;
    endtask

    // sync_at: 0 = never, -1 = every clock, k = only on clock k of the cycle
    task automatic wr_cycle(input logic [15:0] a, input logic [7:0] d, input int n,
                            input int sync_at, output int stbs, output int stb_at);
        stbs = 0; stb_at = 0;
        bus_if.bus_a = a; bus_if.bus_d = d;
        bus_if.bus_ioreq = 1'b1; bus_if.bus_wr = 1'b1; bus_if.bus_rd = 1'b0;
        for (int k = 1; k <= n; k++) begin
            sync_ck = (sync_at == -1) || (sync_at == k);
            @(negedge clk28);
            if (wr_stb != 4'h0) begin stbs++; stb_at = k; end
        end
        idle();
        @(negedge clk28);
        if (wr_stb != 4'h0) stbs++;
    endtask

    initial begin
        int s, at;
        rst_n = 1'b0; en = 4'hF; unlock = 1'b0;
        bus_if.bus_a = 16'h0; bus_if.bus_d = 8'h0;
        idle();
        repeat (2) @(negedge clk28);
        rst_n = 1'b1;
        @(negedge clk28);
        chk("reset regs", regs, 32'h4433_1000);
        chk("reset locked", {28'h0, locked}, 32'h0);
        chk("reset d_out_active", {31'h0, bus_if.d_out_active}, 32'h0);

        bus_if.bus_a = 16'h00FE; bus_if.bus_ioreq = 1'b1; bus_if.bus_rd = 1'b1;
        @(negedge clk28);
        chk("read ch1 active", {31'h0, bus_if.d_out_active}, 32'h1);
        chk("read ch1 data", {24'h0, bus_if.d_out}, 32'h10);
        idle();
        @(negedge clk28);

        wr_cycle(16'h7FFD, 8'h2A, 4, 0, s, at);
        chk("ch0 write strobes", s, 1);
        chk("ch0 value", {24'h0, regs[7:0]}, 32'h2A);
        chk("ch0 locked", {31'h0, locked[0]}, 32'h1);

        wr_cycle(16'h7FFD, 8'h07, 3, 0, s, at);
        chk("locked write strobes", s, 0);
        chk("locked write value", {24'h0, regs[7:0]}, 32'h2A);
        unlock = 1'b1;
        wr_cycle(16'h7FFD, 8'h07, 2, 0, s, at);
        unlock = 1'b0;
        chk("unlock write value", {24'h0, regs[7:0]}, 32'h07);
        chk("unlock clears lock", {31'h0, locked[0]}, 32'h0);

        wr_cycle(16'hDFFD, 8'h05, 4, 3, s, at);
        chk("sync strobes", s, 1);
        chk("sync strobe clock", at, 3);
        chk("sync value", {24'h0, regs[23:16]}, 32'h05);
        wr_cycle(16'hDFFD, 8'h09, 4, 0, s, at);
        chk("no-sync strobes", s, 0);
        chk("no-sync value", {24'h0, regs[23:16]}, 32'h05);

        wr_cycle(16'h1FFD, 8'h11, 2, 0, s, at);
        chk("overlap ch0", {24'h0, regs[7:0]}, 32'h11);
        chk("overlap ch3", {24'h0, regs[31:24]}, 32'h44);
        en = 4'hE;
        wr_cycle(16'h1FFD, 8'h22, 2, 0, s, at);
        en = 4'hF;
        chk("en0 off ch3", {24'h0, regs[31:24]}, 32'h22);
        chk("en0 off ch0", {24'h0, regs[7:0]}, 32'h11);

        bus_if.bus_a = 16'hDFFD; bus_if.bus_d = 8'h77;
        bus_if.bus_ioreq = 1'b1; bus_if.bus_wr = 1'b1; sync_ck = 1'b0;
        s = 0;
        repeat (2) begin @(negedge clk28); if (wr_stb != 4'h0) s++; end
        #2 rst_n = 1'b0;
        sync_ck = 1'b1;
        repeat (2) begin @(negedge clk28); if (wr_stb != 4'h0) s++; end
        idle();
        rst_n = 1'b1;
        repeat (2) begin @(negedge clk28); if (wr_stb != 4'h0) s++; end
        chk("reset abort strobes", s, 0);
        chk("reset abort regs", regs, 32'h4433_1000);
        wr_cycle(16'hDFFD, 8'h66, 2, -1, s, at);
        chk("post-reset strobes", s, 1);
        chk("post-reset value", {24'h0, regs[23:16]}, 32'h66);

        for (int t = 0; t < 700; t++) begin
            int kind, len;
            logic [15:0] pick [5];
            pick[0] = 16'h7FFD; pick[1] = 16'h00FE; pick[2] = 16'hDFFD;
            pick[3] = 16'h1FFD; pick[4] = 16'($urandom);
            if ($urandom_range(0, 99) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk28);
                rst_n = 1'b1;
            end
            en     = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'hF;
            unlock = ($urandom_range(0, 6) == 0);
            bus_if.bus_a = pick[$urandom_range(0, 4)];
            bus_if.bus_d = 8'($urandom);
            kind = $urandom_range(0, 3);
            bus_if.bus_ioreq = (kind != 0);
            bus_if.bus_rd    = (kind == 1) || (kind == 3);
            bus_if.bus_wr    = (kind == 2) || (kind == 3);
            len = $urandom_range(1, 5);
            for (int k = 0; k < len; k++) begin
                sync_ck = ($urandom_range(0, 3) == 0);
                @(negedge clk28);
            end
            if ($urandom_range(0, 1) == 0) begin
                idle();
                @(negedge clk28);
            end
        end
        idle();
        repeat (2) @(negedge clk28);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/io_port_bank.md
Name: io_port_bank

Overview:
Parametrised bank of NPORTS CPU-writable I/O latch registers for the Z80 I/O space. It is the generalised successor to the hard-coded paging/border port latches.
- Each channel has its own address match/mask, reset value, optional lock bit, optional read-back and optional CPU-clock write synchronisation.
- Sits between the CPU bus decode and the memory/video/FDC control logic, clocked by clk28.
- Read-back data feeds the shared bus data-out mux via d_out/d_out_active.

Parameters:
NPORTS, 4, number of register channels (1..8)
W, 8, register width in bits (1..8); writes take bus_d[W-1:0]
ADDR_MATCH, {NPORTS{16'h0000}}, packed NPORTS*16; channel i address pattern in bits [16i+15:16i]
ADDR_MASK, {NPORTS{16'hFFFF}}, packed NPORTS*16; 1 = address bit compared
RESET_VAL, {NPORTS*W{1'b0}}, packed NPORTS*W; per-channel reset contents
READABLE, {NPORTS{1'b0}}, bit i = channel i drives read data
LOCKABLE, {NPORTS{1'b0}}, bit i = channel i has a sticky lock
LOCK_POS, 5, data bit index that sets the lock on a committed write
SYNC_WR, {NPORTS{1'b0}}, bit i = channel i commits only while sync_ck=1

Ports:
clk28  input  1  system clock, 28 MHz
rst_n  input  1  asynchronous active-low reset
en  input  NPORTS  per-channel enable (mode select); a disabled channel never matches
bus_a  input  16  CPU address
bus_d  input  8  CPU write data
bus_ioreq  input  1  I/O cycle active
bus_rd  input  1  read strobe
bus_wr  input  1  write strobe
sync_ck  input  1  one-clk28 CPU clock-edge pulse used by SYNC_WR channels
unlock  input  1  level; overrides all locks while high
regs  output  NPORTS*W  register contents, channel i in [Wi+W-1:Wi]
wr_stb  output  NPORTS  one-clk28 pulse on the clock where channel i commits
locked  output  NPORTS  sticky lock state
d_out  output  8  read data, zero-extended from W
d_out_active  output  1  d_out is valid and must be driven onto the bus

Behaviour:
- Reset (async, rst_n low):
  - regs=RESET_VAL, locked=0, wr_stb=0, d_out=0, d_out_active=0, wr_done=0.
  - Asserting reset mid-cycle aborts any pending write.
- Match:
  - hit_i = en[i] & bus_ioreq & ((bus_a ^ ADDR_MATCH_i) & ADDR_MASK_i)==0.
  - Lowest-index hit wins (sel); only sel participates in a read or write.
- Write request: wr_req = bus_ioreq & bus_wr & any hit & !wr_done.
- Commit: on the clk28 edge where wr_req, and (!SYNC_WR[sel] | sync_ck), and !(locked[sel] & !unlock):
  - regs_sel <= bus_d[W-1:0];
  - wr_stb[sel] pulses for exactly that cycle (registered, same edge);
  - if LOCKABLE[sel]: locked[sel] <= bus_d[LOCK_POS].
  - wr_done <= 1.
- Blocked write: locked and unlock=0. No register change, no strobe, wr_done <= 1 (cycle consumed).
- SYNC_WR channel with sync_ck=0: the write stays pending, wr_done remains 0, and it commits at the first sync_ck inside the same I/O cycle. If the cycle ends first, the write is dropped.
- wr_done clears on the first clock where !(bus_ioreq & bus_wr). This gives exactly one commit per I/O write cycle regardless of cycle length.
- Lock:
  - Clears only on reset, or by a committed write with LOCK_POS bit=0. Such a write is possible only while unlock=1.
  - LOCK_POS must be < W; otherwise lock is never set.
- Read: latency 1 clk28.
  - d_out_active <= bus_ioreq & bus_rd & !bus_wr & any hit & READABLE[sel].
  - d_out <= zero-extended regs_sel, else 0.
  - If rd and wr are asserted together, the write is handled and no read is signalled.
- A read during the same clock as a commit to the same channel returns the old value. The next clock returns the new value.

Decomposition:
- Package common:
  - port address/mask constants (7FFD 128K decode, DFFD, 1FFD, FE);
  - io_port_cfg_t struct (match, mask, reset, flags) used by top-level instantiation.
- Sub-module io_port_chan: one register and lock flip-flop with commit/lock logic, instantiated NPORTS times via generate.
- Match/priority, wr_done tracking and the read mux stay in io_port_bank.

Test Plan:
- Reset, then read ch1 (READABLE, RESET_VAL=8'h10) -> d_out_active=1 one clk later, d_out=8'h10; regs all equal RESET_VAL.
- Write 8'h2A to ch0 (match 16'h7FFD, mask 16'h8002) using a 4-clk wr cycle -> exactly one wr_stb[0] pulse, regs0=8'h2A, locked[0]=1 (LOCK_POS=5).
- With locked[0]=1, write 8'h07 -> regs0 unchanged, no strobe. Raise unlock and repeat -> regs0=8'h07, locked[0]=0.
- SYNC_WR ch2, write 8'h05 with sync_ck at clk 3 of the cycle -> commit and strobe on clk 3 only. Same write with no sync_ck in the cycle -> regs2 unchanged.
- Address hitting ch0 and ch3 simultaneously -> only ch0 written. With en[0]=0 -> only ch3 written.
- Assert rst_n low during a pending SYNC write -> regs back to RESET_VAL, no strobe after release; the next write cycle commits normally.
